// File: rtl/m_7seg_scan_if.sv
// Datapath-to-scanner bundle: frame codes, load strobe, blanking controls and display pins.
// Purely combinational wiring; it adds no latency.
// No backpressure: load is a strobe and the scanner always accepts it.
// SEG7_BLINK_EN adds the per-digit blink enable to the bundle.
interface m_7seg_scan_if #(
    parameter int N_DIGITS = 4
);
    logic [4*N_DIGITS-1:0] idat;
    logic [N_DIGITS-1:0]   idp;
    logic                  load;
    logic                  lzb;
`ifdef SEG7_BLINK_EN
    logic [N_DIGITS-1:0]   blink;
`endif
    logic [7:0]            oseg;
    logic [N_DIGITS-1:0]   odig;

`ifdef SEG7_BLINK_EN
    modport master (output idat, idp, load, lzb, blink, input oseg, odig);
    modport slave  (input idat, idp, load, lzb, blink, output oseg, odig);
`else
    modport master (output idat, idp, load, lzb, input oseg, odig);
    modport slave  (input idat, idp, load, lzb, output oseg, odig);
`endif
endinterface

// File: rtl/m_7seg_scan.sv
// Time-multiplexed N-digit common-anode 7-segment scanner with a double-buffered frame.
// Outputs registered (one cycle behind cnt/idx); a load shows within one frame plus one cycle.
// No backpressure: loads are always accepted, and the last load before a frame boundary wins.
// SEG7_BLINK_EN enables per-digit blinking with a BLINK_FRAMES half-period.
module m_7seg_scan #(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
`ifdef SEG7_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic           clk,
    input  logic           rst,
    m_7seg_scan_if.slave   bus
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0]       CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]       IDX_LAST = IW'(N_DIGITS - 1);
    localparam logic [CW-1:0]       BLANK_L  = CW'(BLANK_CYC);
    localparam logic [N_DIGITS-1:0] SEL0     = 1;

    logic [CW-1:0]              cnt;
    logic [IW-1:0]              idx;
    logic [N_DIGITS-1:0][3:0]   in_code;
    logic [N_DIGITS-1:0][3:0]   disp_code;
    logic [N_DIGITS-1:0]        disp_dp;
    logic [N_DIGITS-1:0][3:0]   shd_code;
    logic [N_DIGITS-1:0]        shd_dp;
    logic                       pending;
    logic                       slot_end;
    logic                       frame_end;
    logic                       in_gap;
    logic [N_DIGITS-1:0]        lz_blank;
    logic [N_DIGITS-1:0]        blink_blank;
    logic                       lz_run;
    logic [3:0]                 cur_code;
    logic                       cur_dp;
    logic                       cur_blank;
    logic [7:0]                 seg_q;
    logic [N_DIGITS-1:0]        dig_q;

    // Active-low segment pattern {g,f,e,d,c,b,a}; operators A..E, F is dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] c);
        case (c)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h18;
            4'hA: return 7'h39;
            4'hB: return 7'h3F;
            4'hC: return 7'h09;
            4'hD: return 7'h2D;
            4'hE: return 7'h37;
            default: return 7'h7F;
        endcase
    endfunction

    assign in_code   = bus.idat;
    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // The ghost gap is omitted entirely when BLANK_CYC is zero.
    if (BLANK_CYC == 0) begin : g_nogap
        assign in_gap = 1'b0;
    end else begin : g_gap
        assign in_gap = (cnt < BLANK_L);
    end

    // Slot prescaler and digit index; scan order 0..N_DIGITS-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow/display double buffer: swap only on the frame boundary, bypassing a coincident load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_code <= '1;
            disp_dp   <= '0;
            shd_code  <= '1;
            shd_dp    <= '0;
            pending   <= 1'b0;
        end else if (frame_end) begin
            if (bus.load) begin
                disp_code <= in_code;
                disp_dp   <= bus.idp;
            end else if (pending) begin
                disp_code <= shd_code;
                disp_dp   <= shd_dp;
            end
            pending <= 1'b0;
        end else if (bus.load) begin
            shd_code <= in_code;
            shd_dp   <= bus.idp;
            pending  <= 1'b1;
        end
    end

    // Leading-zero mask: digit k>0 dark while it and all higher digits are 0 or F.
    always_comb begin
        lz_run   = 1'b1;
        lz_blank = '0;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            lz_run      = lz_run && ((disp_code[k] == 4'h0) || (disp_code[k] == 4'hF));
            lz_blank[k] = lz_run;
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FR_LAST = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] frm_cnt;
    logic          phase;

    // Frame counter toggles the blink phase every BLINK_FRAMES frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm_cnt <= '0;
            phase   <= 1'b0;
        end else if (frame_end) begin
            if (frm_cnt == FR_LAST) begin
                frm_cnt <= '0;
                phase   <= ~phase;
            end else begin
                frm_cnt <= frm_cnt + 1'b1;
            end
        end
    end

    assign blink_blank = phase ? bus.blink : '0;
`else
    assign blink_blank = '0;
`endif

    assign cur_code  = disp_code[idx];
    assign cur_dp    = disp_dp[idx];
    assign cur_blank = (bus.lzb & lz_blank[idx]) | blink_blank[idx];

    // Registered pin drive; blanked digits keep their select but show all segments (and dp) off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= 8'hFF;
            dig_q <= '1;
        end else if (in_gap) begin
            seg_q <= 8'hFF;
            dig_q <= '1;
        end else begin
            dig_q <= ~(SEL0 << idx);
            seg_q <= cur_blank ? 8'hFF : {~cur_dp, seg_decode(cur_code)};
        end
    end

    assign bus.oseg = seg_q;
    assign bus.odig = dig_q;

endmodule

// File: tb/tb_m_7seg_scan.sv
// Directed bench for m_7seg_scan with N_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
// Positions are (frame, digit, cnt) counted from reset release; outputs sampled 1 ns after the edge.
// Blink scenario is compiled in only with SEG7_BLINK_EN (BLINK_FRAMES=2).
module tb_m_7seg_scan;
    localparam int N  = 4;
    localparam int SD = 8;
    localparam int BC = 2;

    logic clk = 1'b0;
    logic rst;
    int   cyc;
    int   n_chk;
    int   n_pass;

    m_7seg_scan_if #(.N_DIGITS(N)) bus ();

    m_7seg_scan #(
        .N_DIGITS(N),
        .SCAN_DIV(SD),
        .BLANK_CYC(BC)
`ifdef SEG7_BLINK_EN
        ,
        .BLINK_FRAMES(2)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int pos(input int f, input int i, input int c);
        return f * (N * SD) + i * SD + c;
    endfunction

    // After goto(p) the outputs reflect scan position p.
    task automatic goto(input int p);
        if (cyc > p + 1) begin
            n_chk++;
            $display("FAIL goto: position %0d already passed at cycle %0d", p, cyc);
        end
        while (cyc < p + 1) step();
    endtask

    task automatic see(input string tag, input int f, input int i, input int c,
                       input logic [7:0] seg, input logic [3:0] dig);
        goto(pos(f, i, c));
        chk({tag, "_seg"}, bus.oseg, seg);
        chk({tag, "_dig"}, {4'h0, bus.odig}, {4'h0, dig});
    endtask

    // Load strobe is sampled on the edge that leaves position p.
    task automatic load_at(input int p, input logic [15:0] d, input logic [3:0] dp);
        goto(p - 1);
        bus.idat = d;
        bus.idp  = dp;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    function automatic logic [3:0] sel(input int i);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << i);
    endfunction

    logic [7:0] exp_1234 [4];
    logic [7:0] exp_abce [4];

    initial begin
        exp_1234 = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        exp_abce = '{8'hB7, 8'h09, 8'hBF, 8'hB9};
        n_chk  = 0;
        n_pass = 0;
        cyc    = 0;
        bus.idat = '0;
        bus.idp  = '0;
        bus.load = 1'b0;
        bus.lzb  = 1'b0;
`ifdef SEG7_BLINK_EN
        bus.blink = '0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_seg", bus.oseg, 8'hFF);
        chk("reset_dig", {4'h0, bus.odig}, 8'h0F);
        rst = 1'b0;
        cyc = 0;

        // Power-up frame: gap first, then digit 0 dark (all codes F).
        see("first", 0, 0, 0, 8'hFF, 4'hF);
        see("first_act", 0, 0, 2, 8'hFF, 4'hE);
        load_at(pos(0, 0, 3), 16'h1234, 4'b0000);
        see("hold", 0, 1, 4, 8'hFF, 4'hD);

        // Frame 1 shows 1234 with a 2-cycle gap per slot.
        for (int i = 0; i < N; i++) begin
            see($sformatf("gap1_d%0d", i), 1, i, 1, 8'hFF, 4'hF);
            see($sformatf("f1s_d%0d", i), 1, i, 2, exp_1234[i], sel(i));
            see($sformatf("f1e_d%0d", i), 1, i, 7, exp_1234[i], sel(i));
        end

        // Leading-zero blanking; dp is suppressed on a blanked digit.
        bus.lzb = 1'b1;
        load_at(pos(2, 0, 3), 16'h0070, 4'b1001);
        see("lzb_nz", 2, 3, 4, 8'hF9, 4'h7);
        see("lz_d0", 3, 0, 4, 8'h40, 4'hE);
        see("lz_d1", 3, 1, 4, 8'hF8, 4'hD);
        see("lz_d2", 3, 2, 4, 8'hFF, 4'hB);
        see("lz_d3", 3, 3, 4, 8'hFF, 4'h7);
        load_at(pos(3, 3, 5), 16'h0000, 4'b0000);
        see("z_d0", 4, 0, 4, 8'hC0, 4'hE);
        see("z_d1", 4, 1, 3, 8'hFF, 4'hD);
        bus.lzb = 1'b0;
        step();
        chk("lzb_off", bus.oseg, 8'hC0);
        see("z_d3", 4, 3, 4, 8'hC0, 4'h7);

        // Mid-frame loads do not disturb the current frame; the last one wins.
        load_at(pos(5, 0, 4), 16'h9999, 4'b0000);
        load_at(pos(5, 1, 3), 16'hABCE, 4'b0010);
        see("mid_d1", 5, 1, 5, 8'hC0, 4'hD);
        see("mid_d3", 5, 3, 5, 8'hC0, 4'h7);
        for (int i = 0; i < N; i++)
            see($sformatf("ops_d%0d", i), 6, i, 4, exp_abce[i], sel(i));

        // Load on the frame-boundary cycle bypasses straight into the next frame.
        load_at(pos(6, 3, 7), 16'h5555, 4'b0000);
        chk("bnd_old", bus.oseg, 8'hB9);
        see("bnd_gap", 7, 0, 0, 8'hFF, 4'hF);
        see("bnd_d0", 7, 0, 2, 8'h92, 4'hE);

        // Asynchronous reset mid-slot 2 with a load pending.
        load_at(pos(7, 1, 3), 16'h1111, 4'b0000);
        see("pre_rst", 7, 2, 4, 8'h92, 4'hB);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_seg", bus.oseg, 8'hFF);
        chk("arst_dig", {4'h0, bus.odig}, 8'h0F);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        see("rel_gap", 0, 0, 1, 8'hFF, 4'hF);
        see("rel_d0", 0, 0, 2, 8'hFF, 4'hE);
        see("nopend_d0", 1, 0, 4, 8'hFF, 4'hE);
        see("nopend_d1", 1, 1, 4, 8'hFF, 4'hD);

`ifdef SEG7_BLINK_EN
        // Blink phase flips every 2 frames from reset; only digit 0 blinks.
        bus.blink = 4'b0001;
        load_at(pos(1, 2, 3), 16'h2222, 4'b0000);
        see("blk_f2d0", 2, 0, 4, 8'hFF, 4'hE);
        see("blk_f2d1", 2, 1, 4, 8'hA4, 4'hD);
        see("blk_f3d0", 3, 0, 4, 8'hFF, 4'hE);
        see("blk_f4d0", 4, 0, 4, 8'hA4, 4'hE);
        see("blk_f5d0", 5, 0, 4, 8'hA4, 4'hE);
        see("blk_f6d0", 6, 0, 4, 8'hFF, 4'hE);
        see("blk_f6d3", 6, 3, 4, 8'hA4, 4'h7);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
